uart_ram_loader: RTL and testbench

Serial boot loader that sits directly upstream of the Z80 program block RAM and drives its write port. It receives 8N1 UART bytes, parses a framed load command (start address, length, data, checksum), and writes the data bytes one per clock into the RAM. While a load is in progress, and after any failed load, it holds the Z80 in reset. After a successful load it releases the Z80.

---
 rtl/uart_ram_loader.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_uart_ram_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_loader.sv
// uart_ram_loader
// Serial boot loader for the Z80 program RAM. Receives 8N1 UART bytes,
// parses the frame A5, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, data..., CSUM and
// writes each data byte into the RAM one clock after it arrives. The Z80 is
// held in reset while a load runs and after any failed load.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   uart_rx     serial input, idle high, asynchronous to clk
//   ram_addr_w  RAM write address (holds after each write)
//   ram_din     RAM write data (holds after each write)
//   ram_we      RAM write enable, one-cycle pulse per data byte
//   cpu_rst_n   Z80 reset, active low (released at power-up and after a good load)
//   busy        frame in progress
//   done        one-cycle pulse on a successful load
//   err         sticky error flag, cleared by the next frame start
module uart_ram_loader #(
    parameter int CLKS_PER_BIT = 139,
    parameter int ADDR_WIDTH   = 14,
    parameter int MEM_DEPTH    = 15360,
    parameter int TIMEOUT_CLKS = 1600000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rx,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic [7:0]            ram_din,
    output logic                  ram_we,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [16:0]      DEPTH17   = 17'(MEM_DEPTH);

    // ------------------------------------------------------------------
    // Synchronizer plus one extra stage for falling-edge detection
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync, rx_prev;

    // NOTE: non-blocking assignments for all registered state, so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // RX engine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]       rx_bit, rx_bit_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;
    logic             rx_valid, rx_valid_nxt;
    logic             rx_ferr, rx_ferr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
            rx_valid <= rx_valid_nxt;
            rx_ferr  <= rx_ferr_nxt;
        end
    end

    // NOTE: every signal gets a default before the case statement, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_valid_nxt = 1'b0;
        rx_ferr_nxt  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_bit_nxt   = '0;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};  // LSB first
                    rx_bit_nxt   = rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = RX_IDLE;
                    rx_valid_nxt = rx_sync;
                    rx_ferr_nxt  = !rx_sync;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        P_IDLE, P_ADDR_L, P_ADDR_H, P_LEN_L, P_LEN_H, P_DATA, P_CSUM, P_FAIL
    } p_state_t;

    p_state_t              p_state, p_state_nxt;
    logic [7:0]            addr_lo, addr_lo_nxt;
    logic [7:0]            len_lo, len_lo_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
    logic [15:0]           remain, remain_nxt;
    logic [7:0]            sum, sum_nxt;
    logic [TMO_W-1:0]      tmo, tmo_nxt;
    logic [ADDR_WIDTH-1:0] ram_addr_w_nxt;
    logic [7:0]            ram_din_nxt;
    logic                  ram_we_nxt, cpu_rst_n_nxt, busy_nxt, done_nxt, err_nxt;
    logic                  tmo_expired;
    logic [15:0]           addr_full, len_full;
    logic [16:0]           range_end;

    assign addr_full = {rx_shift, addr_lo};
    assign len_full  = {rx_shift, len_lo};
    assign range_end = 17'(cur_addr) + 17'(len_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state    <= P_IDLE;
            addr_lo    <= '0;
            len_lo     <= '0;
            cur_addr   <= '0;
            remain     <= '0;
            sum        <= '0;
            tmo        <= '0;
            ram_addr_w <= '0;
            ram_din    <= '0;
            ram_we     <= 1'b0;
            cpu_rst_n  <= 1'b1;  // RAM is preloaded, so the Z80 runs from power-up
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            p_state    <= p_state_nxt;
            addr_lo    <= addr_lo_nxt;
            len_lo     <= len_lo_nxt;
            cur_addr   <= cur_addr_nxt;
            remain     <= remain_nxt;
            sum        <= sum_nxt;
            tmo        <= tmo_nxt;
            ram_addr_w <= ram_addr_w_nxt;
            ram_din    <= ram_din_nxt;
            ram_we     <= ram_we_nxt;
            cpu_rst_n  <= cpu_rst_n_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        p_state_nxt    = p_state;
        addr_lo_nxt    = addr_lo;
        len_lo_nxt     = len_lo;
        cur_addr_nxt   = cur_addr;
        remain_nxt     = remain;
        sum_nxt        = sum;
        tmo_nxt        = '0;
        ram_addr_w_nxt = ram_addr_w;
        ram_din_nxt    = ram_din;
        ram_we_nxt     = 1'b0;
        cpu_rst_n_nxt  = cpu_rst_n;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        err_nxt        = err;
        tmo_expired    = 1'b0;

        // Counter holds 1 right after a byte, so expiry lands exactly
        // TIMEOUT_CLKS cycles after the last rx_valid.
        if (p_state != P_IDLE) begin
            if (rx_valid)             tmo_nxt = TMO_W'(1);
            else if (tmo == TMO_LAST) tmo_expired = 1'b1;
            else                      tmo_nxt = tmo + 1'b1;
        end

        case (p_state)
            P_IDLE: begin
                if (rx_valid && rx_shift == 8'hA5) begin
                    p_state_nxt   = P_ADDR_L;
                    err_nxt       = 1'b0;
                    busy_nxt      = 1'b1;
                    cpu_rst_n_nxt = 1'b0;
                    tmo_nxt       = TMO_W'(1);
                end
            end
            P_ADDR_L: if (rx_valid) begin
                addr_lo_nxt = rx_shift;
                p_state_nxt = P_ADDR_H;
            end
            P_ADDR_H: if (rx_valid) begin
                if ((addr_full >> ADDR_WIDTH) != 16'd0) begin
                    p_state_nxt = P_FAIL;
                end else begin
                    cur_addr_nxt = addr_full[ADDR_WIDTH-1:0];
                    p_state_nxt  = P_LEN_L;
                end
            end
            P_LEN_L: if (rx_valid) begin
                len_lo_nxt  = rx_shift;
                p_state_nxt = P_LEN_H;
            end
            P_LEN_H: if (rx_valid) begin
                // The 17-bit check guarantees the address never wraps in DATA.
                if (range_end > DEPTH17) begin
                    p_state_nxt = P_FAIL;
                end else begin
                    remain_nxt  = len_full;
                    sum_nxt     = '0;
                    p_state_nxt = (len_full == 16'd0) ? P_CSUM : P_DATA;
                end
            end
            P_DATA: if (rx_valid) begin
                ram_we_nxt     = 1'b1;
                ram_addr_w_nxt = cur_addr;
                ram_din_nxt    = rx_shift;
                cur_addr_nxt   = cur_addr + 1'b1;
                remain_nxt     = remain - 1'b1;
                sum_nxt        = sum + rx_shift;
                if (remain == 16'd1) p_state_nxt = P_CSUM;
            end
            P_CSUM: if (rx_valid) begin
                if (rx_shift == sum) begin
                    done_nxt      = 1'b1;
                    busy_nxt      = 1'b0;
                    cpu_rst_n_nxt = 1'b1;
                    p_state_nxt   = P_IDLE;
                end else begin
                    p_state_nxt = P_FAIL;
                end
            end
            P_FAIL:  p_state_nxt = P_IDLE;
            default: p_state_nxt = P_IDLE;
        endcase

        // Line faults abort any frame in progress.
        if (p_state != P_IDLE && p_state != P_FAIL && (rx_ferr || tmo_expired))
            p_state_nxt = P_FAIL;

        // err rises in the same cycle FAIL is entered; Z80 stays in reset.
        if (p_state_nxt == P_FAIL) begin
            err_nxt       = 1'b1;
            busy_nxt      = 1'b0;
            cpu_rst_n_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader. Uses a short bit time and timeout so
// the whole run stays small. Bytes are driven on falling clock edges; each
// send returns on the falling edge right after the parser has reacted, so
// pulses such as ram_we and done are visible at that point.
module tb_uart_ram_loader;

    localparam int CPB  = 8;
    localparam int AW   = 14;
    localparam int DEP  = 15360;
    localparam int TMO  = 1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          uart_rx;
    logic [AW-1:0] ram_addr_w;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic          err;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int w0;

    uart_ram_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW),
        .MEM_DEPTH   (DEP),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .ram_addr_w(ram_addr_w),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Count write pulses independently of the per-byte checks.
    always @(posedge clk) if (ram_we === 1'b1) we_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic send_data(input logic [7:0] b, input logic [AW-1:0] a, input string tag);
        send_byte(b, 1'b1);
        check({tag, ".we"},   ram_we, 1);
        check({tag, ".addr"}, ram_addr_w, a);
        check({tag, ".din"},  ram_din, b);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".addr"}, ram_addr_w, 0);
        check({tag, ".din"},  ram_din, 0);
        check({tag, ".we"},   ram_we, 0);
        check({tag, ".cpu"},  cpu_rst_n, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".err"},  err, 0);
    endtask

    task automatic check_done(input string tag);
        check({tag, ".done"}, done, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".cpu"},  cpu_rst_n, 1);
        check({tag, ".err"},  err, 0);
    endtask

    task automatic check_fail(input string tag);
        check({tag, ".err"},  err, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".cpu"},  cpu_rst_n, 0);
        check({tag, ".done"}, done, 0);
    endtask

    initial begin
        uart_rx = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Good load: 11 22 33 at 0x100, checksum 0x66
        w0 = we_cnt;
        send(8'hA5);
        check("good.busy_rise", busy, 1);
        check("good.cpu_low",   cpu_rst_n, 0);
        send(8'h00); send(8'h01); send(8'h03); send(8'h00);
        send_data(8'h11, 14'h100, "good.d0");
        send_data(8'h22, 14'h101, "good.d1");
        send_data(8'h33, 14'h102, "good.d2");
        send(8'h66);
        check_done("good.end");
        @(negedge clk);
        check("good.done_1cyc", done, 0);
        check("good.addr_hold", ram_addr_w, 14'h102);
        check("good.din_hold",  ram_din, 8'h33);
        check("good.we_count",  we_cnt - w0, 3);
        repeat (10) @(negedge clk);

        // Bad checksum: both bytes written, then failure
        w0 = we_cnt;
        send(8'hA5); send(8'h10); send(8'h00); send(8'h02); send(8'h00);
        send_data(8'hAA, 14'h010, "bcs.d0");
        send_data(8'hBB, 14'h011, "bcs.d1");
        send(8'h00);
        check_fail("bcs.end");
        check("bcs.we_count", we_cnt - w0, 2);
        repeat (5) @(negedge clk);
        check("bcs.err_sticky", err, 1);

        // Following good frame clears err and releases the Z80
        send(8'hA5);
        check("recov.err_clr", err, 0);
        check("recov.cpu_low", cpu_rst_n, 0);
        send(8'h00); send(8'h02); send(8'h01); send(8'h00);
        send_data(8'hC3, 14'h200, "recov.d0");
        send(8'hC3);
        check_done("recov.end");
        repeat (10) @(negedge clk);

        // Range: 0x3BFF + 2 > 15360, fails after LEN_HI with no writes
        w0 = we_cnt;
        send(8'hA5); send(8'hFF); send(8'h3B); send(8'h02);
        check("range.busy_mid", busy, 1);
        send(8'h00);
        check_fail("range.end");
        repeat (3 * CPB * 10) @(negedge clk);
        check("range.we_count", we_cnt - w0, 0);

        // Range boundary: 0x3BFF + 1 == 15360 is allowed
        send(8'hA5); send(8'hFF); send(8'h3B); send(8'h01); send(8'h00);
        send_data(8'h5A, 14'h3BFF, "edge.d0");
        send(8'h5A);
        check_done("edge.end");
        repeat (10) @(negedge clk);

        // Address high bits beyond ADDR_WIDTH set: fail after ADDR_HI
        w0 = we_cnt;
        send(8'hA5); send(8'h00); send(8'h40);
        check_fail("hiaddr.end");
        check("hiaddr.we_count", we_cnt - w0, 0);
        repeat (10) @(negedge clk);

        // Zero length
        w0 = we_cnt;
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        send(8'h00);
        check_done("zero.end");
        check("zero.we_count", we_cnt - w0, 0);
        repeat (10) @(negedge clk);

        // 0xA5 inside a frame is payload
        send(8'hA5); send(8'h00); send(8'h00); send(8'h01); send(8'h00);
        send_data(8'hA5, 14'h000, "sync.d0");
        send(8'hA5);
        check_done("sync.end");
        repeat (10) @(negedge clk);

        // Glitch shorter than half a bit inside DATA produces no byte
        w0 = we_cnt;
        send(8'hA5); send(8'h00); send(8'h02); send(8'h01); send(8'h00);
        uart_rx = 1'b0;
        repeat (CPB / 2 - 1) @(negedge clk);
        uart_rx = 1'b1;
        repeat (15 * CPB) @(negedge clk);
        check("glitch.busy", busy, 1);
        check("glitch.we_count", we_cnt - w0, 0);
        send_data(8'h3C, 14'h200, "glitch.d0");
        send(8'h3C);
        check_done("glitch.end");
        repeat (10) @(negedge clk);

        // Stop bit forced low mid-DATA
        w0 = we_cnt;
        send(8'hA5); send(8'h00); send(8'h03); send(8'h02); send(8'h00);
        send_data(8'h12, 14'h300, "ferr.d0");
        send_byte(8'h34, 1'b0);
        check_fail("ferr.end");
        check("ferr.we_count", we_cnt - w0, 1);
        repeat (20) @(negedge clk);

        // Timeout after LEN_LO: err exactly TMO cycles after last rx_valid
        send(8'hA5); send(8'h00); send(8'h00); send(8'h05);
        repeat (TMO - 2) @(negedge clk);
        check("tmo.before", err, 0);
        check("tmo.busy_before", busy, 1);
        @(negedge clk);
        check_fail("tmo.at");
        repeat (10) @(negedge clk);

        // Async reset during DATA
        send(8'hA5); send(8'h00); send(8'h01); send(8'h04); send(8'h00);
        send_data(8'h77, 14'h100, "arst.d0");
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("arst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send(8'h33);
        check("arst.idle_ignore", busy, 0);
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        send(8'h00);
        check_done("arst.after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
